tile_renderer: RTL and testbench
================================

Name: tile_renderer

Overview:
- Pipelined, parametrised successor to the combinational tile/sprite colour generator.
- Converts the current VGA pixel coordinate, the packed tile map, up to NUM_PLAYERS player positions and the game stage into registered 24-bit RGB.
- Reads all sprite art from one external synchronous sprite ROM over a registered address/select port.
- Adds a per-frame animation phase for bomb and flame tiles, and a pause stage that freezes it.

Parameters:
GRID_W, 10, map columns (cells along X)
GRID_H, 10, map rows (cells along Y)
TILE_W, 64, tile and player sprite width in pixels
TILE_H, 48, tile and player sprite height in pixels
CELL_BITS, 3, bits per map cell code
NUM_PLAYERS, 2, player sprites, 1..4
ANIM_DIV, 15, frames per animation phase toggle, >=1
ADDR_W, 13, sprite ROM address width, >= clog2(2*TILE_W*TILE_H)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse once per frame (vsync)
pixel_valid  in  1  DrawX/DrawY is an active-area pixel this cycle
DrawX  in  10  pixel column
DrawY  in  10  pixel row
stage  in  2  0 title, 1 play, 2 game over, 3 paused
map_1d  in  GRID_W*GRID_H*CELL_BITS  packed map; cell (0,0) in the MSBs
player_x  in  10*NUM_PLAYERS  player p X at bits [10p+:10]
player_y  in  10*NUM_PLAYERS  player p Y at bits [10p+:10]
player_alive  in  NUM_PLAYERS  player p drawn only when 1
rom_addr  out  ADDR_W  sprite ROM address, registered
rom_sel  out  4  sprite ROM bank select, registered
rom_rgb  in  24  {R,G,B}; ROM registers it on the edge after rom_addr/rom_sel change
Red, Green, Blue  out  8 each  registered pixel colour
out_valid  out  1  Red/Green/Blue correspond to a valid pixel
anim_phase  out  1  current animation phase

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - All pipeline registers cleared.
  - Red, Green, Blue, out_valid, rom_addr, rom_sel, anim_phase all 0.
  - Animation frame counter set to 0.
- Pipeline, fixed latency 4 edges from the input sample to RGB out:
  - Edge 1 (S1): sample and decode the pixel.
  - Edge 2 (S2): register rom_addr and rom_sel.
  - Edge 3: the ROM registers rom_rgb.
  - Edge 4: output register.
  - pixel_valid and stage travel with the pixel through every stage. No stalls.
- S1 decode:
  - Cell index: cx = DrawX/TILE_W, cy = DrawY/TILE_H, i = cx*GRID_H + cy.
  - Cell code: bits [(GRID_W*GRID_H-1-i)*CELL_BITS +: CELL_BITS].
  - If cx>=GRID_W or cy>=GRID_H, the code is forced to 0.
  - Tile offsets: dx = DrawX % TILE_W, dy = DrawY % TILE_H.
- Player hit:
  - Compute ux = DrawX-player_x[p] and uy = DrawY-player_y[p] as 10-bit unsigned (wrap).
  - Player p hits when ux<TILE_W, uy<TILE_H and player_alive[p]=1.
  - The lowest hitting index wins. For a player hit, dx=ux and dy=uy.
- rom_sel encoding:
  - 8+p for the winning player (players override tiles).
  - Otherwise by cell code: 1 flame, 2 monster, 3 wall, 4 brick, 5 bomb.
  - Codes 0, 6 and 7 give 0 (background; ROM data ignored).
- rom_addr = ph*TILE_W*TILE_H + dy*TILE_W + dx.
  - ph = anim_phase for bomb (5) and flame (1); ph = 0 for all other selects.
  - anim_phase is sampled at S2.
- Output stage (edge 4), by delayed state:
  - pixel_valid=0: RGB = 0, out_valid = 0.
  - stage 0: RGB = FF,FF,FF.
  - stage 2: RGB = 00,00,00.
  - stage 1 or 3, sel=0: RGB = 00,5D,09.
  - stage 1 or 3, sel≠0: RGB = rom_rgb.
  - out_valid = delayed pixel_valid.
- Animation counter, updated on frame_start:
  - stage 1: counter increments. At ANIM_DIV-1 it wraps to 0 and anim_phase toggles.
  - stage 3: counter and phase hold.
  - stage 0 or 2: counter and phase clear to 0.
  - ANIM_DIV=1: anim_phase toggles every frame_start in stage 1.
- Reset mid-frame: every in-flight pixel is discarded (out_valid=0). Output resumes 4 edges after the first valid pixel following release.

Test Plan:
- Reset asserted mid-stream -> all outputs 0 immediately. After release, first valid pixel at (0,0) gives out_valid=1 exactly 4 edges later.
- Defaults, stage=1, map cell (2,3)=3, DrawX=130, DrawY=150 -> rom_sel=3 and rom_addr=6*64+2=386 two edges after the sample; RGB equals the ROM word 2 edges later.
- player_x[0]=player_x[1]=100, player_y=50, both alive, DrawX=110, DrawY=60 -> rom_sel=8, rom_addr=650. Kill player 0 -> rom_sel=9.
- Cell code 5, 15 frame_start pulses in stage 1 -> anim_phase=1; bomb rom_addr offset by 3072. Stage 3 plus 30 pulses -> phase unchanged. Stage 0 pulse -> phase 0.
- DrawX=640 with GRID_W=10 -> background 00,5D,09. stage=0 -> FF,FF,FF. stage=2 -> 0,0,0. pixel_valid=0 -> out_valid=0, RGB 0.
- Player at X=1020, DrawX=2 -> ux wraps to 6, so a player hit.

Source files
------------

// File: rtl/tile_renderer.sv
// Pipelined tile/sprite colour generator: decodes the VGA pixel against the tile map and
// players, fetches sprite art from an external synchronous ROM, and registers 24-bit RGB.
module tile_renderer #(
    parameter int GRID_W      = 10,
    parameter int GRID_H      = 10,
    parameter int TILE_W      = 64,
    parameter int TILE_H      = 48,
    parameter int CELL_BITS   = 3,
    parameter int NUM_PLAYERS = 2,
    parameter int ANIM_DIV    = 15,
    parameter int ADDR_W      = 13
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            frame_start,
    input  logic                            pixel_valid,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic [1:0]                      stage,
    input  logic [GRID_W*GRID_H*CELL_BITS-1:0] map_1d,
    input  logic [10*NUM_PLAYERS-1:0]       player_x,
    input  logic [10*NUM_PLAYERS-1:0]       player_y,
    input  logic [NUM_PLAYERS-1:0]          player_alive,
    output logic [ADDR_W-1:0]               rom_addr,
    output logic [3:0]                      rom_sel,
    input  logic [23:0]                     rom_rgb,
    output logic [7:0]                      Red,
    output logic [7:0]                      Green,
    output logic [7:0]                      Blue,
    output logic                            out_valid,
    output logic                            anim_phase
);

    localparam int NCELL     = GRID_W * GRID_H;
    localparam int MAP_W     = NCELL * CELL_BITS;
    localparam int MAP_IDX_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int CNT_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [1:0] STAGE_TITLE = 2'd0;
    localparam logic [1:0] STAGE_PLAY  = 2'd1;
    localparam logic [1:0] STAGE_OVER  = 2'd2;
    localparam logic [1:0] STAGE_PAUSE = 2'd3;

    // S1 decode
    logic [9:0]           cx, cy, dx, dy, ux, uy;
    logic                 in_grid;
    logic [15:0]          cell_i;
    logic [MAP_IDX_W-1:0] cell_lsb;
    logic [MAP_W-1:0]     map_shift;
    logic [CELL_BITS-1:0] cell_code;
    logic [3:0]           tile_sel, hit_sel;
    logic                 hit;
    logic [9:0]           hit_dx, hit_dy;

    logic       s1_valid_d, s1_valid_q;
    logic [1:0] s1_stage_d, s1_stage_q;
    logic [3:0] s1_sel_d, s1_sel_q;
    logic [9:0] s1_dx_d, s1_dx_q, s1_dy_d, s1_dy_q;

    logic              s2_valid_q;
    logic [1:0]        s2_stage_q;
    logic              ph;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic [3:0]        rom_sel_q;

    logic       s3_valid_q;
    logic [1:0] s3_stage_q;
    logic       s3_bg_q;

    logic [23:0] rgb_d, rgb_q;
    logic        out_valid_q;

    logic [CNT_W-1:0] anim_cnt_d, anim_cnt_q;
    logic             anim_phase_d, anim_phase_q;

    always_comb begin
        cx        = DrawX / 10'(TILE_W);
        cy        = DrawY / 10'(TILE_H);
        dx        = DrawX % 10'(TILE_W);
        dy        = DrawY % 10'(TILE_H);
        in_grid   = (cx < 10'(GRID_W)) && (cy < 10'(GRID_H));
        cell_i    = 16'(cx) * 16'(GRID_H) + 16'(cy);
        // Off-map pixels use shift 0 so the select never runs past the map vector
        cell_lsb  = in_grid ? MAP_IDX_W'((16'(NCELL - 1) - cell_i) * 16'(CELL_BITS)) : '0;
        map_shift = map_1d >> cell_lsb;
        cell_code = in_grid ? map_shift[CELL_BITS-1:0] : '0;

        case (int'(cell_code))
            1, 2, 3, 4, 5: tile_sel = 4'(cell_code);
            default:       tile_sel = 4'd0;
        endcase

        hit     = 1'b0;
        hit_sel = 4'd0;
        hit_dx  = '0;
        hit_dy  = '0;
        ux      = '0;
        uy      = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            ux = DrawX - player_x[10*p +: 10];
            uy = DrawY - player_y[10*p +: 10];
            if (!hit && player_alive[p] && (ux < 10'(TILE_W)) && (uy < 10'(TILE_H))) begin
                hit     = 1'b1;
                hit_sel = 4'(8 + p);
                hit_dx  = ux;
                hit_dy  = uy;
            end
        end

        s1_valid_d = pixel_valid;
        s1_stage_d = stage;
        s1_sel_d   = hit ? hit_sel : tile_sel;
        s1_dx_d    = hit ? hit_dx : dx;
        s1_dy_d    = hit ? hit_dy : dy;
    end

    // Only flame and bomb art has a second animation frame
    always_comb begin
        ph         = anim_phase_q && ((s1_sel_q == 4'd1) || (s1_sel_q == 4'd5));
        rom_addr_d = ADDR_W'((ph ? TILE_W * TILE_H : 0) + int'(s1_dy_q) * TILE_W + int'(s1_dx_q));
    end

    always_comb begin
        rgb_d = 24'h000000;
        if (s3_valid_q) begin
            case (s3_stage_q)
                STAGE_TITLE: rgb_d = 24'hFFFFFF;
                STAGE_OVER:  rgb_d = 24'h000000;
                default:     rgb_d = s3_bg_q ? 24'h005D09 : rom_rgb;
            endcase
        end
    end

    always_comb begin
        anim_cnt_d   = anim_cnt_q;
        anim_phase_d = anim_phase_q;
        if (frame_start) begin
            case (stage)
                STAGE_PLAY: begin
                    if (anim_cnt_q == CNT_W'(ANIM_DIV - 1)) begin
                        anim_cnt_d   = '0;
                        anim_phase_d = ~anim_phase_q;
                    end else begin
                        anim_cnt_d = anim_cnt_q + 1'b1;
                    end
                end
                STAGE_PAUSE: ;
                default: begin
                    anim_cnt_d   = '0;
                    anim_phase_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_stage_q   <= '0;
            s1_sel_q     <= '0;
            s1_dx_q      <= '0;
            s1_dy_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_stage_q   <= '0;
            rom_addr_q   <= '0;
            rom_sel_q    <= '0;
            s3_valid_q   <= 1'b0;
            s3_stage_q   <= '0;
            s3_bg_q      <= 1'b0;
            rgb_q        <= '0;
            out_valid_q  <= 1'b0;
            anim_cnt_q   <= '0;
            anim_phase_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_stage_q   <= s1_stage_d;
            s1_sel_q     <= s1_sel_d;
            s1_dx_q      <= s1_dx_d;
            s1_dy_q      <= s1_dy_d;
            s2_valid_q   <= s1_valid_q;
            s2_stage_q   <= s1_stage_q;
            rom_addr_q   <= rom_addr_d;
            rom_sel_q    <= s1_sel_q;
            s3_valid_q   <= s2_valid_q;
            s3_stage_q   <= s2_stage_q;
            s3_bg_q      <= (rom_sel_q == 4'd0);
            rgb_q        <= rgb_d;
            out_valid_q  <= s3_valid_q;
            anim_cnt_q   <= anim_cnt_d;
            anim_phase_q <= anim_phase_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rom_sel    = rom_sel_q;
    assign Red        = rgb_q[23:16];
    assign Green      = rgb_q[15:8];
    assign Blue       = rgb_q[7:0];
    assign out_valid  = out_valid_q;
    assign anim_phase = anim_phase_q;

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: a vector table for the decode/colour paths plus
// hand-written sequences for reset latency and the animation counter.
module tb_tile_renderer;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         frame_start;
    logic         pixel_valid;
    logic [9:0]   DrawX, DrawY;
    logic [1:0]   stage;
    logic [299:0] map_1d;
    logic [19:0]  player_x, player_y;
    logic [1:0]   player_alive;
    logic [12:0]  rom_addr;
    logic [3:0]   rom_sel;
    logic [23:0]  rom_rgb;
    logic [7:0]   Red, Green, Blue;
    logic         out_valid;
    logic         anim_phase;

    int n_cmp = 0;
    int n_err = 0;

    tile_renderer dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .DrawX(DrawX), .DrawY(DrawY), .stage(stage), .map_1d(map_1d),
        .player_x(player_x), .player_y(player_y), .player_alive(player_alive),
        .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_rgb(rom_rgb),
        .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid), .anim_phase(anim_phase)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] rom_fn(input logic [3:0] sel, input logic [12:0] addr);
        return {sel, 7'h2A, addr};
    endfunction

    always @(posedge Clk) rom_rgb <= rom_fn(rom_sel, rom_addr);

    function automatic logic [299:0] one_cell(input int cx, input int cy, input int code);
        logic [299:0] m;
        logic [2:0]   c;
        int           i;
        m = '0;
        c = 3'(code);
        i = cx * 10 + cy;
        if (code != 0) m[(99 - i) * 3 +: 3] = c;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse(input int n);
        for (int k = 0; k < n; k++) begin
            frame_start = 1'b1;
            tick(1);
            frame_start = 1'b0;
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  stg;
        logic        valid;
        int          x, y;
        int          ccx, ccy, ccode;
        int          px0, py0, px1, py1;
        logic [1:0]  alive;
        logic        chk_rom;
        logic [3:0]  sel;
        logic [12:0] addr;
        logic [23:0] rgb;
        logic        ov;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input string name, input logic [1:0] stg, input logic valid,
                                input int x, input int y, input int ccx, input int ccy,
                                input int ccode, input int px0, input int py0, input int px1,
                                input int py1, input logic [1:0] alive, input logic chk_rom,
                                input logic [3:0] sel, input logic [12:0] addr,
                                input logic [23:0] rgb, input logic ov);
        vec_t v;
        v.name = name; v.stg = stg; v.valid = valid; v.x = x; v.y = y;
        v.ccx = ccx; v.ccy = ccy; v.ccode = ccode;
        v.px0 = px0; v.py0 = py0; v.px1 = px1; v.py1 = py1; v.alive = alive;
        v.chk_rom = chk_rom; v.sel = sel; v.addr = addr; v.rgb = rgb; v.ov = ov;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        stage        = v.stg;
        pixel_valid  = v.valid;
        DrawX        = 10'(v.x);
        DrawY        = 10'(v.y);
        map_1d       = one_cell(v.ccx, v.ccy, v.ccode);
        player_x     = {10'(v.px1), 10'(v.px0)};
        player_y     = {10'(v.py1), 10'(v.py0)};
        player_alive = v.alive;
    endtask

    initial begin
        Reset_n = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
        DrawX = '0; DrawY = '0; stage = 2'd1; map_1d = '0;
        player_x = '0; player_y = '0; player_alive = '0;

        vt[0]  = mk("wall_cell",   2'd1, 1, 130, 150, 2, 3, 3, 500, 500, 500, 500, 2'b00, 1, 4'd3, 13'd386,  rom_fn(4'd3, 13'd386),  1);
        vt[1]  = mk("player0_win", 2'd1, 1, 110,  60, 0, 0, 0, 100,  50, 100,  50, 2'b11, 1, 4'd8, 13'd650,  rom_fn(4'd8, 13'd650),  1);
        vt[2]  = mk("player1_only",2'd1, 1, 110,  60, 0, 0, 0, 100,  50, 100,  50, 2'b10, 1, 4'd9, 13'd650,  rom_fn(4'd9, 13'd650),  1);
        vt[3]  = mk("off_map_x",   2'd1, 1, 640,  10, 9, 0, 3, 500, 500, 500, 500, 2'b00, 1, 4'd0, 13'd640,  24'h005D09,             1);
        vt[4]  = mk("title",       2'd0, 1, 130, 150, 2, 3, 3, 500, 500, 500, 500, 2'b00, 1, 4'd3, 13'd386,  24'hFFFFFF,             1);
        vt[5]  = mk("game_over",   2'd2, 1, 130, 150, 2, 3, 3, 500, 500, 500, 500, 2'b00, 1, 4'd3, 13'd386,  24'h000000,             1);
        vt[6]  = mk("not_valid",   2'd1, 0, 130, 150, 2, 3, 3, 500, 500, 500, 500, 2'b00, 0, 4'd0, 13'd0,    24'h000000,             0);
        vt[7]  = mk("x_wrap",      2'd1, 1,   2,   5, 0, 0, 0,1020,   0, 500, 500, 2'b01, 1, 4'd8, 13'd326,  rom_fn(4'd8, 13'd326),  1);
        vt[8]  = mk("bomb_pause",  2'd3, 1,   5,   7, 0, 0, 5, 500, 500, 500, 500, 2'b00, 1, 4'd5, 13'd453,  rom_fn(4'd5, 13'd453),  1);
        vt[9]  = mk("code6_bg",    2'd1, 1,  70,  50, 1, 1, 6, 500, 500, 500, 500, 2'b00, 1, 4'd0, 13'd134,  24'h005D09,             1);
        vt[10] = mk("flame_corner",2'd1, 1, 639, 479, 9, 9, 1, 500, 500, 500, 500, 2'b00, 1, 4'd1, 13'd3071, rom_fn(4'd1, 13'd3071), 1);
        vt[11] = mk("brick_col0",  2'd1, 1,   0, 432, 0, 9, 4, 500, 500, 500, 500, 2'b00, 1, 4'd4, 13'd0,    rom_fn(4'd4, 13'd0),    1);
        vt[12] = mk("player_over", 2'd1, 1, 130, 150, 2, 3, 3, 500, 500, 128, 144, 2'b10, 1, 4'd9, 13'd386,  rom_fn(4'd9, 13'd386),  1);
        vt[13] = mk("player_edge", 2'd1, 1, 130, 150, 2, 3, 3,  66, 140, 500, 500, 2'b01, 1, 4'd3, 13'd386,  rom_fn(4'd3, 13'd386),  1);

        tick(2);
        chk("rst_rgb",   {8'h0, Red, Green, Blue}, 32'h0);
        chk("rst_ov",    32'(out_valid), 32'h0);
        chk("rst_sel",   32'(rom_sel), 32'h0);
        chk("rst_addr",  32'(rom_addr), 32'h0);
        chk("rst_phase", 32'(anim_phase), 32'h0);
        Reset_n = 1'b1;
        tick(1);

        for (int v = 0; v < 14; v++) begin
            drive(vt[v]);
            tick(2);
            if (vt[v].chk_rom) begin
                chk({vt[v].name, "_sel"},  32'(rom_sel),  32'(vt[v].sel));
                chk({vt[v].name, "_addr"}, 32'(rom_addr), 32'(vt[v].addr));
            end
            tick(2);
            chk({vt[v].name, "_rgb"}, {8'h0, Red, Green, Blue}, {8'h0, vt[v].rgb});
            chk({vt[v].name, "_ov"},  32'(out_valid), 32'(vt[v].ov));
        end

        // Reset mid-stream, then a single valid pixel at (0,0)
        drive(vt[0]);
        tick(4);
        chk("pre_rst_ov", 32'(out_valid), 32'h1);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_ov",   32'(out_valid), 32'h0);
        chk("mid_rst_rgb",  {8'h0, Red, Green, Blue}, 32'h0);
        chk("mid_rst_sel",  32'(rom_sel), 32'h0);
        chk("mid_rst_addr", 32'(rom_addr), 32'h0);
        pixel_valid = 1'b0;
        tick(2);
        Reset_n = 1'b1; DrawX = '0; DrawY = '0; map_1d = '0; player_alive = '0;
        stage = 2'd1; pixel_valid = 1'b1;
        tick(1);
        pixel_valid = 1'b0;
        chk("lat_e1", 32'(out_valid), 32'h0);
        tick(1);
        chk("lat_e2", 32'(out_valid), 32'h0);
        tick(1);
        chk("lat_e3", 32'(out_valid), 32'h0);
        tick(1);
        chk("lat_e4",     32'(out_valid), 32'h1);
        chk("lat_e4_rgb", {8'h0, Red, Green, Blue}, 32'h005D09);
        tick(1);
        chk("lat_e5", 32'(out_valid), 32'h0);

        // Animation phase: bomb at (0,0), pixel (5,7) -> base address 453
        stage = 2'd1; pixel_valid = 1'b1; DrawX = 10'd5; DrawY = 10'd7;
        map_1d = one_cell(0, 0, 5);
        frame_pulse(14);
        chk("anim_14", 32'(anim_phase), 32'h0);
        frame_pulse(1);
        chk("anim_15", 32'(anim_phase), 32'h1);
        tick(2);
        chk("bomb_ph1_sel",  32'(rom_sel), 32'h5);
        chk("bomb_ph1_addr", 32'(rom_addr), 32'd3525);
        map_1d = one_cell(0, 0, 3);
        tick(2);
        chk("wall_ph1_addr", 32'(rom_addr), 32'd453);
        map_1d = one_cell(0, 0, 1);
        tick(2);
        chk("flame_ph1_addr", 32'(rom_addr), 32'd3525);
        stage = 2'd3;
        map_1d = one_cell(0, 0, 5);
        frame_pulse(30);
        chk("pause_hold", 32'(anim_phase), 32'h1);
        tick(2);
        chk("pause_bomb_addr", 32'(rom_addr), 32'd3525);
        tick(2);
        chk("pause_bomb_rgb", {8'h0, Red, Green, Blue}, {8'h0, rom_fn(4'd5, 13'd3525)});
        stage = 2'd0;
        frame_pulse(1);
        chk("title_clear", 32'(anim_phase), 32'h0);

        // Counter value must survive a pause between play frames
        stage = 2'd1;
        frame_pulse(7);
        stage = 2'd3;
        frame_pulse(5);
        stage = 2'd1;
        frame_pulse(7);
        chk("cnt_hold_14", 32'(anim_phase), 32'h0);
        frame_pulse(1);
        chk("cnt_hold_15", 32'(anim_phase), 32'h1);
        stage = 2'd2;
        frame_pulse(1);
        chk("over_clear", 32'(anim_phase), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
